// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared widths, FSM states and way index type for sa_cache.
package sa_cache_pkg;
  localparam int TAG_W = 18;
  localparam int IDX_W = 8;
  localparam int OFF_W = 6;
  localparam int WAYS = 4;
  localparam int SETS = 256;
  localparam int WORDS = 16;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  typedef logic [1:0] way_t;
endpackage

// File: rtl/sa_cache_repl.sv
// sa_cache_repl: per-set replacement state and victim choice; SA_CACHE_PLRU_EN selects tree PLRU over round robin.
module sa_cache_repl
  import sa_cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [IDX_W-1:0] idx,
  input  logic hit,
  input  way_t hit_way,
  input  logic fill,
  input  way_t fill_way,
  input  logic fill_repl,
  output way_t victim
);
`ifdef SA_CACHE_PLRU_EN
  logic [2:0] bits [SETS];
  logic [2:0] b;
  way_t uw;
  logic unused;
  assign unused = fill_repl;
  assign b = bits[idx];
  assign victim = {b[0], b[0] ? b[2] : b[1]};
  assign uw = fill ? fill_way : hit_way;
  // bit0 points at the pair not touched, bit1/bit2 at the sibling within the touched pair
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int s = 0; s < SETS; s++) bits[s] <= '0;
    else if (hit || fill) bits[idx] <= uw[1] ? {~uw[0], b[1], 1'b0} : {b[2], ~uw[0], 1'b1};
`else
  logic [1:0] ptr [SETS];
  logic unused;
  assign unused = ^{hit, hit_way, fill_way};
  assign victim = ptr[idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    else if (fill && fill_repl) ptr[idx] <= ptr[idx] + 2'd1;
`endif
endmodule

// File: rtl/sa_cache.sv
// sa_cache: 4-way write-back, write-allocate cache with 16-beat refill/writeback bursts.
// Define SA_CACHE_PLRU_EN for tree pseudo-LRU replacement instead of round robin.
module sa_cache
  import sa_cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [IDX_W-1:0] i_index,
  input  logic [OFF_W-1:0] i_offset,
  input  logic [31:0] dataW,
  input  logic memRW,
  input  logic [31:0] i_memory_line,
  input  logic i_memory_response,
  output logic [31:0] o_data,
  output logic [31:0] line_data,
  output logic cache_miss,
  output logic [31:0] evict_data,
  output logic [31:0] evict_addr,
  output logic evict
);
  logic [31:0] data [WAYS][SETS][WORDS];
  logic [TAG_W-1:0] tags [WAYS][SETS];
  logic [SETS-1:0] valid [WAYS];
  logic [SETS-1:0] dirty [WAYS];
  state_t state;
  logic [3:0] cnt, word;
  way_t vway, hit_way, inv_way, repl_way, victim;
  logic [WAYS-1:0] match;
  logic hit, all_valid, vrepl, resp, fill, unused;
  logic [31:0] last_word, hit_word;
  always_comb begin
    match = '0;
    hit_way = '0;
    inv_way = '0;
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = valid[w][i_index] && tags[w][i_index] == i_tag;
      if (match[w]) hit_way = way_t'(w);
      if (!valid[w][i_index]) begin
        inv_way = way_t'(w);
        all_valid = 1'b0;
      end
    end
  end
  assign hit = |match;
  assign word = i_offset[5:2];
  assign unused = ^i_offset[1:0];
  assign victim = all_valid ? repl_way : inv_way;
  assign hit_word = data[hit_way][i_index][word];
  assign resp = state == REFILL && i_memory_response;
  assign fill = resp && cnt == 4'hF;
  sa_cache_repl u_repl (
    .clk(clk),
    .rst(rst),
    .idx(i_index),
    .hit(state == IDLE && hit),
    .hit_way(hit_way),
    .fill(fill),
    .fill_way(vway),
    .fill_repl(vrepl),
    .victim(repl_way)
  );
  // The victim is invalidated on the miss edge so a partial refill never looks valid.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      vway <= '0;
      vrepl <= 1'b0;
      last_word <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
    end else if (state == IDLE) begin
      if (hit && memRW) dirty[hit_way][i_index] <= 1'b1;
      else if (!hit) begin
        vway <= victim;
        vrepl <= all_valid;
        valid[victim][i_index] <= 1'b0;
        state <= valid[victim][i_index] && dirty[victim][i_index] ? WRITEBACK : REFILL;
      end
    end else if (state == WRITEBACK) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'hF) state <= REFILL;
    end else if (resp) begin
      cnt <= cnt + 4'd1;
      last_word <= i_memory_line;
      if (fill) begin
        valid[vway][i_index] <= 1'b1;
        dirty[vway][i_index] <= 1'b0;
        state <= IDLE;
      end
    end
  always_ff @(posedge clk) begin
    if (state == IDLE && hit && memRW) data[hit_way][i_index][word] <= dataW;
    if (resp) data[vway][i_index][cnt] <= i_memory_line;
    if (fill) tags[vway][i_index] <= i_tag;
  end
  assign evict = state == WRITEBACK;
  assign evict_data = evict ? data[vway][i_index][cnt] : '0;
  assign evict_addr = evict ? {tags[vway][i_index], i_index, cnt, 2'b00} : '0;
  assign cache_miss = !rst && (state != IDLE || !hit);
  assign o_data = state == IDLE && hit && !memRW ? hit_word : '0;
  assign line_data = state == REFILL ? last_word : hit ? hit_word : '0;
endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed scoreboard bench for sa_cache (default round-robin build).
module tb_sa_cache;
  logic clk = 1'b0, rst = 1'b1;
  logic [17:0] i_tag;
  logic [7:0] i_index;
  logic [5:0] i_offset;
  logic [31:0] dataW, i_memory_line, o_data, line_data, evict_data, evict_addr;
  logic memRW, i_memory_response, cache_miss, evict;
  typedef struct packed {logic [31:0] a; logic [31:0] d;} beat_t;
  beat_t wb_q[$];
  logic [31:0] rd_q[$];
  int checks = 0, errors = 0;
  sa_cache dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
    .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
    .cache_miss(cache_miss), .evict_data(evict_data), .evict_addr(evict_addr), .evict(evict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [17:0] t, input logic [7:0] x, input logic [5:0] o,
                     input logic rw, input logic [31:0] d);
    i_tag = t;
    i_index = x;
    i_offset = o;
    memRW = rw;
    dataW = d;
    #1;
  endtask
  task automatic pop_rd(input string tag);
    logic [31:0] e;
    if (rd_q.size() == 0) chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    else begin
      e = rd_q.pop_front();
      chk(tag, o_data, e);
    end
  endtask
  task automatic refill(input logic [31:0] base, input bit gap);
    for (int k = 0; k < 16; k++) begin
      if (gap && k == 5) begin
        i_memory_response = 1'b0;
        step();
        chk("gap_hold_miss", {31'd0, cache_miss}, 32'd1);
        chk("gap_line_data", line_data, base + 32'd4);
      end
      i_memory_response = 1'b1;
      i_memory_line = base + 32'(k);
      step();
    end
    i_memory_response = 1'b0;
    #1;
  endtask
  initial begin
    int n;
    i_memory_response = 1'b0;
    i_memory_line = '0;
    req(18'h0, 8'h00, 6'h00, 1'b0, 32'h0);
    chk("rst_miss", {31'd0, cache_miss}, 32'd0);
    chk("rst_evict", {31'd0, evict}, 32'd0);
    chk("rst_odata", o_data, 32'd0);
    chk("rst_line_data", line_data, 32'd0);
    step();
    step();
    i_tag = 18'h1;
    i_index = 8'h05;
    i_offset = 6'h08;
    rst = 1'b0;
    #1;
    chk("miss_detect", {31'd0, cache_miss}, 32'd1);
    chk("miss_odata", o_data, 32'd0);
    rd_q.push_back(32'h102);
    step();
    chk("clean_no_evict", {31'd0, evict}, 32'd0);
    chk("refill_miss", {31'd0, cache_miss}, 32'd1);
    refill(32'h100, 1'b0);
    chk("hit_after_refill", {31'd0, cache_miss}, 32'd0);
    pop_rd("read_after_refill");
    req(18'h1, 8'h05, 6'h08, 1'b1, 32'hDEADBEEF);
    chk("write_hit_miss", {31'd0, cache_miss}, 32'd0);
    chk("write_hit_odata", o_data, 32'd0);
    step();
    rd_q.push_back(32'hDEADBEEF);
    req(18'h1, 8'h05, 6'h08, 1'b0, 32'h0);
    pop_rd("read_after_write");
    chk("write_no_evict", {31'd0, evict}, 32'd0);
    for (int t = 2; t <= 4; t++) begin
      req(18'(t), 8'h05, 6'h08, 1'b0, 32'h0);
      chk("fill_miss", {31'd0, cache_miss}, 32'd1);
      step();
      chk("fill_no_evict", {31'd0, evict}, 32'd0);
      rd_q.push_back((32'(t) << 8) + 32'd2);
      refill(32'(t) << 8, t == 3);
      pop_rd("fill_read");
    end
    req(18'h5, 8'h05, 6'h00, 1'b0, 32'h0);
    chk("dirty_miss", {31'd0, cache_miss}, 32'd1);
    for (int k = 0; k < 16; k++)
      wb_q.push_back({32'h4140 + 32'(4 * k), k == 2 ? 32'hDEADBEEF : 32'h100 + 32'(k)});
    rd_q.push_back(32'h500);
    step();
    n = 0;
    for (int g = 0; g < 40 && n < 16; g++) begin
      if (evict) begin
        beat_t e;
        e = wb_q.pop_front();
        chk("wb_addr", evict_addr, e.a);
        chk("wb_data", evict_data, e.d);
        n++;
      end
      step();
    end
    chk("wb_beat_count", 32'(n), 32'd16);
    chk("wb_done_evict", {31'd0, evict}, 32'd0);
    chk("wb_done_miss", {31'd0, cache_miss}, 32'd1);
    refill(32'h500, 1'b0);
    pop_rd("read_after_wb_refill");
    req(18'h1, 8'h05, 6'h08, 1'b0, 32'h0);
    chk("evicted_remiss", {31'd0, cache_miss}, 32'd1);
    step();
    chk("clean_victim_no_evict", {31'd0, evict}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      i_memory_response = 1'b1;
      i_memory_line = 32'h700 + 32'(k);
      step();
    end
    i_memory_line = 32'h707;
    rst = 1'b1;
    #1;
    chk("midburst_rst_miss", {31'd0, cache_miss}, 32'd0);
    chk("midburst_rst_evict", {31'd0, evict}, 32'd0);
    chk("midburst_rst_line", line_data, 32'd0);
    step();
    rst = 1'b0;
    i_memory_response = 1'b0;
    #1;
    chk("post_rst_remiss", {31'd0, cache_miss}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_cache.md
Name: sa_cache

Overview:
- 4-way set-associative, write-back, write-allocate data cache. 32-bit address split tag[17:0] / index[7:0] / offset[5:0].
- 256 sets; 64-byte lines of 16 32-bit words.
- Sits between a single-issue requester and a 32-bit memory port.
- Refills by a 16-beat inbound burst; writes dirty victims back by a 16-beat outbound burst.

Parameters:
- WAYS, 4, associativity (fixed; replacement logic sized for 4).
- SETS, 256, number of sets (= 2^index width).
- WORDS, 16, 32-bit words per line (= 64 B / 4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_tag  in  18  request address [31:14].
- i_index  in  8  request address [13:6].
- i_offset  in  6  byte offset [5:0]; word select = i_offset[5:2]; [1:0] ignored.
- dataW  in  32  write data.
- memRW  in  1  1 = write, 0 = read.
- i_memory_line  in  32  refill beat data.
- i_memory_response  in  1  refill beat strobe; one word per asserted cycle.
- o_data  out  32  read data on a read hit, else 0.
- line_data  out  32  hit-way word at the current word offset; during REFILL, the last word written.
- cache_miss  out  1  high from miss detection until refill completes.
- evict_data  out  32  writeback beat data.
- evict_addr  out  32  writeback beat byte address.
- evict  out  1  writeback beat strobe.

Behaviour:
- Every IDLE cycle the inputs form a request; no separate valid signal.
- The requester must hold i_tag, i_index, i_offset, dataW and memRW stable while cache_miss = 1.
- Hit means: the valid bit is set and the stored tag equals i_tag in exactly one way of set i_index. Lookup is combinational.
- Read hit: o_data = word[i_offset[5:2]] in the same cycle. Replacement state updates at the edge.
- Write hit: dataW is written to that word at the edge. Dirty bit set; replacement state updated. o_data = 0.
- Miss (no way matches):
  - cache_miss goes high combinationally.
  - Victim = first invalid way, lowest index first. If all ways are valid, the replacement policy picks the victim.
  - The victim is latched at the edge.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK: 16 consecutive cycles, evict = 1.
  - Beat k (0..15): evict_data = victim word k; evict_addr = {victim tag, i_index, k[3:0], 2'b00}.
  - No backpressure. Then go to REFILL.
- REFILL: each cycle with i_memory_response = 1 writes i_memory_line into victim word k, for k = 0..15 in order.
  - Cycles without the strobe wait indefinitely.
  - After beat 15: set tag = i_tag, valid = 1, dirty = 0; go to IDLE.
  - The next cycle re-looks-up and hits: a read returns data; a write then performs the write and sets dirty.
- States: IDLE, WRITEBACK, REFILL.
  - cache_miss = 1 in WRITEBACK, REFILL, and in IDLE on a miss.
- i_memory_response outside REFILL is ignored.
- Reset (asynchronous, any state):
  - All valid and dirty bits cleared; replacement state cleared.
  - State = IDLE; beat counter = 0.
  - Outputs forced 0: evict, evict_data, evict_addr, cache_miss, o_data, line_data.
  - Data arrays need no reset.
  - Reset mid-burst aborts the burst; a partial line stays invalid.
- Arithmetic: beat counter 4 bits, wraps 15→0 on completion.
- Simultaneous events: a write hit and a replacement update in the same set occur in the same cycle.

Optional Feature:
- Macro SA_CACHE_PLRU_EN.
- Defined: tree pseudo-LRU, 3 bits per set.
  - Bit0 chooses the pair {0,1} vs {2,3}; bit1 and bit2 choose within each pair.
  - Every hit or refill completion points the bits away from the accessed way.
  - The victim follows the bits.
- Undefined: per-set 2-bit round-robin pointer.
  - Victim = pointer; pointer increments (wrapping 3→0) on each refill completion that used it.
  - Hits do not change the pointer.

Decomposition:
- Package sa_cache_pkg holds:
  - widths: TAG_W=18, IDX_W=8, OFF_W=6, WAYS, SETS, WORDS;
  - state enum {IDLE, WRITEBACK, REFILL};
  - a way-index typedef (2-bit).
- One natural sub-module: sa_cache_repl, the per-set replacement state plus victim selection. It contains the PLRU / round-robin variants.

Test Plan:
- Reset, then read tag=0x1, idx=0x05, off=0x08 → cache_miss=1. Feed 16 beats 0x100+k → next cycle o_data=0x102, cache_miss=0.
- Write 0xDEADBEEF to that address (hit) → a later read returns 0xDEADBEEF; no evict activity.
- Fill all 4 ways of set 0x05 (tags 1..4), dirty tag 1, then miss on tag 5:
  - round robin: victim way 0 (tag 1);
  - 16 evict beats, first evict_addr=0x00004140, evict_data word0;
  - then refill.
- Miss on a clean victim → no evict pulses; REFILL starts the next cycle.
- Insert idle cycles (i_memory_response=0) between refill beats → counter holds and the line fills correctly.
- Assert rst during beat 7 of a refill → cache_miss and evict drop immediately; the same address re-misses after reset.
